wb2core: RTL and testbench

Wishbone pipelined slave to Ibex-style core memory interface bridge: the responder-side counterpart of the core-to-Wishbone converter. It sits in front of any device that speaks the req/gnt/rvalid core protocol, such as on-chip RAM or a peripheral register file, and makes it addressable as a Wishbone slave. It tracks up to MAX_OUTSTANDING granted-but-unanswered transfers. It also discards responses orphaned by a Wishbone cycle abort (cyc dropped early), so they are never misattributed to a later cycle.

---
 rtl/wb2core_if.sv | 40 ++++
 rtl/wb2core.sv | 68 ++++++
 tb/tb_wb2core.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/wb2core_if.sv
// Bus bundle between a pipelined Wishbone master and a req/gnt/rvalid
// device, with the bridge sitting on the slave modport.
interface wb2core_if;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_i;
    logic        wb_stall;
    logic        wb_ack;
    logic        wb_err;
    logic [31:0] wb_dat_o;
    logic        core_req;
    logic        core_gnt;
    logic [31:0] core_addr;
    logic        core_we;
    logic [3:0]  core_be;
    logic [31:0] core_wdata;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        core_err;
    logic        proto_err;

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_i,
        output wb_stall, wb_ack, wb_err, wb_dat_o,
        output core_req, core_addr, core_we, core_be, core_wdata,
        input  core_gnt, core_rvalid, core_rdata, core_err,
        output proto_err
    );

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_i,
        input  wb_stall, wb_ack, wb_err, wb_dat_o,
        input  core_req, core_addr, core_we, core_be, core_wdata,
        output core_gnt, core_rvalid, core_rdata, core_err,
        input  proto_err
    );
endinterface

// File: rtl/wb2core.sv
// Wishbone pipelined slave to req/gnt/rvalid core-memory bridge. Counts
// outstanding transfers and swallows responses orphaned by a cycle abort.
module wb2core #(
    parameter int MAX_OUTSTANDING = 2
) (
    input logic     clk,
    input logic     rst,
    wb2core_if.slave bus
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] out_left;
    logic          proto_err_q, proto_err_d;
    logic          full, draining, accept;
    logic          rsp_drop, rsp_cur, rsp_orphan;

    assign bus.core_addr  = bus.wb_adr;
    assign bus.core_we    = bus.wb_we;
    assign bus.core_be    = bus.wb_sel;
    assign bus.core_wdata = bus.wb_dat_i;
    assign bus.wb_dat_o   = bus.core_rdata;
    assign bus.proto_err  = proto_err_q;

    always_comb begin
        full     = (out_cnt_q == MAX_CNT);
        draining = (drop_cnt_q != '0);

        // Gated by rst so request/termination outputs fall with reset itself.
        bus.core_req = ~rst & bus.wb_cyc & bus.wb_stb & ~full & ~draining;
        accept       = bus.core_req & bus.core_gnt;
        bus.wb_stall = full | draining | (bus.wb_stb & ~bus.core_gnt);

        // Orphaned responses take priority; they are older than anything current.
        rsp_drop   = bus.core_rvalid & draining;
        rsp_cur    = bus.core_rvalid & ~draining & (out_cnt_q != '0);
        rsp_orphan = bus.core_rvalid & ~draining & (out_cnt_q == '0);

        bus.wb_ack = ~rst & rsp_cur & ~bus.core_err;
        bus.wb_err = ~rst & rsp_cur & bus.core_err;

        out_left   = out_cnt_q - CW'(rsp_cur);
        drop_cnt_d = drop_cnt_q - CW'(rsp_drop);
        out_cnt_d  = out_left + CW'(accept);

        // Cycle dropped with transfers still in flight: their responses belong to nobody.
        if (!bus.wb_cyc && out_left != '0) begin
            drop_cnt_d = drop_cnt_d + out_left;
            out_cnt_d  = '0;
        end

        proto_err_d = proto_err_q | rsp_orphan;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            out_cnt_q   <= out_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end
endmodule

// File: tb/tb_wb2core.sv
// Directed bench for wb2core: expected terminations are queued when a request
// is granted and consumed by a monitor whenever the bridge terminates.
module tb_wb2core;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb2core_if bus ();

    wb2core #(.MAX_OUTSTANDING(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        err;
        logic        dchk;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic err, input logic dchk, input logic [31:0] data);
        sb.push_back('{err: err, dchk: dchk, data: data});
    endtask

    // Scoreboard consumer: every termination must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (bus.wb_ack || bus.wb_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_term", {30'd0, bus.wb_err, bus.wb_ack}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("term_ack", {31'd0, bus.wb_ack}, {31'd0, ~mon_e.err});
                chk("term_err", {31'd0, bus.wb_err}, {31'd0, mon_e.err});
                if (mon_e.dchk) chk("term_data", bus.wb_dat_o, mon_e.data);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.wb_cyc = 0; bus.wb_stb = 0; bus.wb_we = 0; bus.wb_adr = '0;
        bus.wb_sel = '0; bus.wb_dat_i = '0; bus.core_gnt = 0;
        bus.core_rvalid = 0; bus.core_rdata = '0; bus.core_err = 0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_ack", {31'd0, bus.wb_ack}, 32'd0);
        chk("rst_err", {31'd0, bus.wb_err}, 32'd0);
        chk("rst_req", {31'd0, bus.core_req}, 32'd0);
        chk("rst_stall", {31'd0, bus.wb_stall}, 32'd0);
        chk("rst_proto", {31'd0, bus.proto_err}, 32'd0);
        tick(); rst = 0;

        // single write, rvalid two cycles after grant
        tick();
        bus.wb_cyc = 1; bus.wb_stb = 1; bus.wb_we = 1; bus.wb_adr = 32'h100;
        bus.wb_sel = 4'hF; bus.wb_dat_i = 32'hDEADBEEF; bus.core_gnt = 1;
        #2;
        chk("wr_req", {31'd0, bus.core_req}, 32'd1);
        chk("wr_addr", bus.core_addr, 32'h100);
        chk("wr_we", {31'd0, bus.core_we}, 32'd1);
        chk("wr_be", {28'd0, bus.core_be}, 32'hF);
        chk("wr_wdata", bus.core_wdata, 32'hDEADBEEF);
        chk("wr_stall", {31'd0, bus.wb_stall}, 32'd0);
        push(0, 0, '0);
        tick(); bus.wb_stb = 0; bus.core_gnt = 0; bus.wb_we = 0;
        #2; chk("wr_req_off", {31'd0, bus.core_req}, 32'd0);
        tick(); bus.core_rvalid = 1; bus.core_rdata = '0;
        #2; chk("wr_ack", {31'd0, bus.wb_ack}, 32'd1);
        tick(); bus.core_rvalid = 0; bus.wb_cyc = 0;

        // pipelined reads, rvalid three cycles after each grant
        tick(); bus.wb_cyc = 1; bus.wb_stb = 1; bus.wb_adr = 32'h200; bus.core_gnt = 1;
        #2; chk("pr_req0", {31'd0, bus.core_req}, 32'd1); push(0, 1, 32'h11);
        tick(); bus.wb_adr = 32'h204;
        #2; chk("pr_stall1", {31'd0, bus.wb_stall}, 32'd0); push(0, 1, 32'h22);
        tick(); bus.wb_adr = 32'h208;
        #2; chk("pr_full_stall", {31'd0, bus.wb_stall}, 32'd1);
        chk("pr_full_req", {31'd0, bus.core_req}, 32'd0);
        tick(); bus.core_rvalid = 1; bus.core_rdata = 32'h11;
        #2; chk("pr_rv_stall", {31'd0, bus.wb_stall}, 32'd1);
        chk("pr_rv_ack", {31'd0, bus.wb_ack}, 32'd1);
        tick(); bus.core_rdata = 32'h22;
        #2; chk("pr_third_req", {31'd0, bus.core_req}, 32'd1);
        chk("pr_third_stall", {31'd0, bus.wb_stall}, 32'd0);
        push(0, 1, 32'h33);
        tick(); bus.wb_stb = 0; bus.core_gnt = 0; bus.core_rvalid = 0;
        tick();
        tick(); bus.core_rvalid = 1; bus.core_rdata = 32'h33;
        #2; chk("pr_last_ack", {31'd0, bus.wb_ack}, 32'd1);
        tick(); bus.core_rvalid = 0; bus.wb_cyc = 0;

        // error response
        tick(); bus.wb_cyc = 1; bus.wb_stb = 1; bus.wb_adr = 32'h300; bus.core_gnt = 1;
        push(1, 0, '0);
        tick(); bus.wb_stb = 0; bus.core_gnt = 0; bus.core_rvalid = 1;
        bus.core_err = 1; bus.core_rdata = 32'hBAD;
        #2; chk("er_err", {31'd0, bus.wb_err}, 32'd1);
        chk("er_ack", {31'd0, bus.wb_ack}, 32'd0);
        tick(); bus.core_rvalid = 0; bus.core_err = 0; bus.wb_cyc = 0;

        // abort with two reads in flight, new cycle waits out both orphans
        tick(); bus.wb_cyc = 1; bus.wb_stb = 1; bus.wb_adr = 32'h400; bus.core_gnt = 1;
        tick(); bus.wb_adr = 32'h404;
        #2; chk("ab_req1", {31'd0, bus.core_req}, 32'd1);
        tick(); bus.wb_cyc = 0; bus.wb_stb = 0; bus.core_gnt = 0;
        tick(); bus.wb_cyc = 1; bus.wb_stb = 1; bus.core_gnt = 1; bus.wb_adr = 32'h500;
        bus.core_rvalid = 1; bus.core_rdata = 32'hAAAA;
        #2; chk("ab_o1_stall", {31'd0, bus.wb_stall}, 32'd1);
        chk("ab_o1_req", {31'd0, bus.core_req}, 32'd0);
        chk("ab_o1_ack", {31'd0, bus.wb_ack}, 32'd0);
        tick(); bus.core_rdata = 32'hBBBB;
        #2; chk("ab_o2_stall", {31'd0, bus.wb_stall}, 32'd1);
        chk("ab_o2_req", {31'd0, bus.core_req}, 32'd0);
        chk("ab_o2_term", {30'd0, bus.wb_err, bus.wb_ack}, 32'd0);
        tick(); bus.core_rvalid = 0;
        #2; chk("ab_new_req", {31'd0, bus.core_req}, 32'd1);
        chk("ab_new_stall", {31'd0, bus.wb_stall}, 32'd0);
        push(0, 1, 32'h44);
        tick(); bus.wb_stb = 0; bus.core_gnt = 0; bus.core_rvalid = 1; bus.core_rdata = 32'h44;
        #2; chk("ab_new_ack", {31'd0, bus.wb_ack}, 32'd1);
        tick(); bus.core_rvalid = 0; bus.wb_cyc = 0;

        // cyc drop together with rvalid: that response still acks
        tick(); bus.wb_cyc = 1; bus.wb_stb = 1; bus.wb_adr = 32'h600; bus.core_gnt = 1;
        push(0, 1, 32'h66);
        tick(); bus.wb_adr = 32'h604;
        tick(); bus.wb_cyc = 0; bus.wb_stb = 0; bus.core_gnt = 0;
        bus.core_rvalid = 1; bus.core_rdata = 32'h66;
        #2; chk("sd_ack", {31'd0, bus.wb_ack}, 32'd1);
        tick(); bus.core_rvalid = 0; bus.wb_cyc = 1; bus.wb_stb = 1; bus.core_gnt = 1;
        #2; chk("sd_drain_stall", {31'd0, bus.wb_stall}, 32'd1);
        tick(); bus.core_rvalid = 1; bus.core_rdata = 32'h77;
        #2; chk("sd_orphan_req", {31'd0, bus.core_req}, 32'd0);
        tick(); bus.core_rvalid = 0;
        #2; chk("sd_new_req", {31'd0, bus.core_req}, 32'd1); push(0, 1, 32'h88);
        tick(); bus.wb_stb = 0; bus.core_gnt = 0; bus.core_rvalid = 1; bus.core_rdata = 32'h88;
        tick(); bus.core_rvalid = 0; bus.wb_cyc = 0;

        // spurious rvalid while idle
        tick(); bus.core_rvalid = 1; bus.core_rdata = 32'h5A;
        #2; chk("sp_term", {30'd0, bus.wb_err, bus.wb_ack}, 32'd0);
        chk("sp_proto_pre", {31'd0, bus.proto_err}, 32'd0);
        tick(); bus.core_rvalid = 0;
        #2; chk("sp_proto_set", {31'd0, bus.proto_err}, 32'd1);
        repeat (3) tick();
        #2; chk("sp_proto_sticky", {31'd0, bus.proto_err}, 32'd1);

        // reset mid-transfer
        tick(); rst = 1;
        tick(); rst = 0;
        #2; chk("mr_proto_clr", {31'd0, bus.proto_err}, 32'd0);
        tick(); bus.wb_cyc = 1; bus.wb_stb = 1; bus.wb_adr = 32'h700; bus.core_gnt = 1;
        tick(); bus.core_gnt = 0;
        #2; rst = 1;
        #1; chk("mr_req", {31'd0, bus.core_req}, 32'd0);
        chk("mr_term", {30'd0, bus.wb_err, bus.wb_ack}, 32'd0);
        tick(); rst = 0; bus.wb_cyc = 0; bus.wb_stb = 0;
        tick(); bus.core_rvalid = 1; bus.core_rdata = 32'h99;
        #2; chk("mr_late_ack", {31'd0, bus.wb_ack}, 32'd0);
        tick(); bus.core_rvalid = 0;
        #2; chk("mr_late_proto", {31'd0, bus.proto_err}, 32'd1);

        tick();
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
